// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer drives the master side; the adder sits on the slave side.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             subtract;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, subtract, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, subtract, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice walks the operands LSB first,
// one bit per clock, then holds the result until the consumer takes it.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] a_sh_next;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_sh_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             carry_next;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_next;
  logic             cout_q;
  logic             cout_next;
  logic             ovf_q;
  logic             ovf_next;
  logic             in_ready_q;
  logic             in_ready_next;
  logic             out_valid_q;
  logic             out_valid_next;

  logic             bit_sum_c;
  logic             bit_carry_c;
  logic             last_bit_c;

  // Single one-bit full-adder slice fed from the low end of the shift registers.
  always_comb begin
    bit_sum_c   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_carry_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit_c  = (idx == IDXW'(WIDTH - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    a_sh_next  = a_sh;
    b_sh_next  = b_sh;
    acc_next   = acc;
    sum_next   = sum_q;
    carry_next = carry;
    idx_next   = idx;
    cout_next  = cout_q;
    ovf_next   = ovf_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtract is a + ~b + 1, so invert b and force the initial carry.
          a_sh_next  = bus.a;
          b_sh_next  = bus.b ^ {WIDTH{bus.subtract}};
          carry_next = bus.subtract | bus.carry_in;
          idx_next   = '0;
          acc_next   = '0;
          state_next = ADD;
        end
      end

      ADD: begin
        a_sh_next            = a_sh >> 1;
        b_sh_next            = b_sh >> 1;
        acc_next             = acc >> 1;
        acc_next[WIDTH-1]    = bit_sum_c;
        carry_next           = bit_carry_c;
        idx_next             = idx + IDXW'(1);
        if (last_bit_c) begin
          // carry holds the carry into the MSB while the MSB is being processed.
          sum_next   = acc_next;
          cout_next  = bit_carry_c;
          ovf_next   = carry ^ bit_carry_c;
          state_next = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      a_sh        <= a_sh_next;
      b_sh        <= b_sh_next;
      acc         <= acc_next;
      sum_q       <= sum_next;
      carry       <= carry_next;
      idx         <= idx_next;
      cout_q      <= cout_next;
      ovf_q       <= ovf_next;
      in_ready_q  <= in_ready_next;
      out_valid_q <= out_valid_next;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule
